// File: rtl/ssd_mux.sv
// rtl/ssd_mux.sv - multiplexed seven-segment scan driver with frame snapshot, blanking, dp and PWM
module ssd_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_PERIOD = 50000,
    parameter int BRIGHT_W     = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz_in,
    input  logic [BRIGHT_W-1:0]     bright_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);

    localparam int TW = $clog2(DIGIT_PERIOD);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DIGIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [TW-1:0]             timer;
    logic [IW-1:0]             idx;
    logic [BRIGHT_W-1:0]       pwm;
    logic [4*NUM_DIGITS-1:0]   sh_val;
    logic [NUM_DIGITS-1:0]     sh_dp;
    logic                      sh_blank;
    logic [BRIGHT_W-1:0]       sh_bright;

    logic [3:0]                nib;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic                      zero_run;
    logic [6:0]                cat_next;
    logic [NUM_DIGITS-1:0]     an_next;
    logic                      timer_wrap;
    logic                      last_slot;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        timer_wrap = (timer == TIMER_LAST);
        last_slot  = timer_wrap && (idx == IDX_LAST);
        nib        = sh_val[{idx, 2'b00} +: 4];

        // Scan from the top digit down; a digit is a leading zero while
        // every nibble from it upward is zero. Digit 0 always shows.
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (sh_val[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
        lz_mask[0] = 1'b0;

        cat_next = (sh_blank && lz_mask[idx]) ? 7'h7F : seg_decode(nib);

        // timer==0 is the ghosting guard: anodes stay off while the
        // cathodes settle onto the new digit.
        an_next = '1;
        if ((timer != '0) && (pwm <= sh_bright))
            an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            timer     <= '0;
            idx       <= '0;
            pwm       <= '0;
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= 1'b0;
            sh_bright <= '0;
            cat_out   <= 7'h7F;
            dp_out    <= 1'b1;
            an_out    <= '1;
            frame_out <= 1'b0;
        end else begin
            pwm <= pwm + 1'b1;
            if (timer_wrap) begin
                timer <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end

            // Inputs are only sampled on the last cycle of a frame so a
            // whole frame always shows one coherent value.
            if (last_slot) begin
                sh_val    <= val_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_lz_in;
                sh_bright <= bright_in;
            end

            cat_out   <= cat_next;
            dp_out    <= ~sh_dp[idx];
            an_out    <= an_next;
            frame_out <= (idx == '0) && (timer == '0);
        end
    end

endmodule
